timer_device: RTL and testbench
===============================

Name: timer_device

Overview:
- Memory-mapped countdown timer that the CPU-side address bridge selects for the window 0x7F00-0x7F0B (the second instance sits at 0x7F10-0x7F1B).
- Decodes bridge writes into three word registers (CTRL, PRESET, COUNT) and returns read data combinationally.
- Counts PRESET down to zero and raises an interrupt request that feeds the HWInt inputs of CP0.

Parameters:
- PRESCALE, 1, number of enabled clock cycles per COUNT decrement; legal range 1-255. Used only when TIMER_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- sel  in  1  bridge chip-select for this device's window.
- we  in  1  write strobe; acts only when sel=1.
- addr  in  2  word offset, byte address [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped.
- wdata  in  32  write data; always a full word.
- rdata  out  32  read data.
- irq  out  1  interrupt request to CP0.

Behaviour:
- Registers:
  - CTRL[0] EN, CTRL[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), CTRL[3] IM (interrupt mask). CTRL[31:4] are stored as 0 and read as 0.
  - PRESET is 32 bits, read/write.
  - COUNT is 32 bits, read-only. Writes to offset 2 or 3 are ignored; the bridge raises the store exception for them.
- Reads are combinational with zero latency: rdata = CTRL, PRESET or COUNT by addr; addr=3 or sel=0 gives 0.
- Writes take effect at the clock edge where sel&we=1 and are visible on rdata in the next cycle.
- Reset (reset=0 at an edge), applied from any state and also mid-count: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. After reset, rdata=0 for every address and irq=0.
- FSM states IDLE, LOAD, CNT, INT. Transitions evaluated each edge:
  - IDLE: EN=1 goes to LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT with EN=0: go to IDLE and hold COUNT.
  - CNT with EN=1 and COUNT>1: COUNT<=COUNT-1.
  - CNT with EN=1 and COUNT<=1: COUNT<=0; go to INT. PRESET=0 therefore reaches INT two cycles after LOAD.
  - INT, MODE one-shot: EN<=0, irq_flag<=1, go to IDLE.
  - INT, MODE auto-reload: irq_flag<=1 for exactly one cycle, go to LOAD.
- COUNT never wraps below 0.
- irq = irq_flag & IM, registered and glitch-free.
- One-shot irq_flag stays set until a bus write to CTRL or PRESET clears it. Auto-reload irq_flag clears automatically on the next edge.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as INT clearing EN: the bus value wins.
  - A bus write to PRESET during CNT does not affect the current count; it is used at the next LOAD.
  - A write of CTRL with EN=0 during CNT stops counting next cycle; COUNT is frozen and stays readable.
- Total latency from enabling CTRL to irq in one-shot mode: PRESET+2 cycles after the write edge, for PRESET>=1.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - An 8-bit prescale counter is added. In CNT, COUNT decrements only when the prescale counter reaches PRESCALE-1; the prescale counter then returns to 0.
  - The prescale counter resets to 0 on reset, in LOAD, and whenever EN=0.
  - Latency to INT becomes PRESET*PRESCALE+1 cycles after LOAD.
- Undefined: no prescale logic; COUNT decrements every CNT cycle and the PRESCALE parameter is ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles after random writes -> CTRL, PRESET and COUNT read 0x00000000 and irq=0.
- One-shot: PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; irq=1 is observed 7 edges after the CTRL write; CTRL then reads 0x8. irq stays 1 until a write of PRESET=5, after which irq=0.
- Auto-reload: PRESET=3, CTRL=0xB -> irq pulses high for 1 cycle every 5 cycles (LOAD, CNT x3, INT), repeating for at least 3 periods.
- Mask and stop: PRESET=10, CTRL=0x1 (IM=0) -> irq stays 0 throughout. Write CTRL=0x0 while COUNT=6 -> COUNT holds 6 for 20 cycles.
- Illegal and reserved accesses: write 0x1234 to addr=2 -> COUNT unchanged. Write CTRL=0xFFFFFFFF -> CTRL reads 0x0000000F. Read addr=3 -> 0.
- With TIMER_PRESCALE_EN and PRESCALE=4: PRESET=2, CTRL=0x9 -> COUNT steps every 4 cycles and irq rises 10 cycles after the write.

Source files
------------

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a masked interrupt request.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (PRESCALE legal range 1-255).
module timer_device #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl, ctrl_eff, ctrl_nxt;
  logic [31:0] preset, count, count_nxt;
  logic        irq_flag, flag_nxt;
  logic        wr_ctrl, wr_preset, en, auto_rl, tick;

  assign wr_ctrl   = sel & we & (addr == 2'd0);
  assign wr_preset = sel & we & (addr == 2'd1);

  // A CTRL write landing this edge is what the FSM acts on, so enabling
  // or stopping takes effect at the write edge itself.
  assign ctrl_eff = wr_ctrl ? wdata[3:0] : ctrl;
  assign en       = ctrl_eff[0];
  assign auto_rl  = (ctrl_eff[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);
  logic [7:0] psc, psc_nxt;

  assign tick = (psc == PSC_LAST);

  always_comb begin
    psc_nxt = 8'd0;
    if ((state == CNT) && en && !tick) psc_nxt = psc + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) psc <= 8'd0;
    else        psc <= psc_nxt;
  end
`else
  // Without the prescaler every CNT cycle is a decrement; PRESCALE has no effect.
  assign tick = 1'b1 | (PRESCALE == 0);
`endif

  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl_eff;
    count_nxt = count;
    flag_nxt  = irq_flag;
    // LOAD is only reached after an auto-reload INT or a CTRL write, so
    // clearing here retires the one-cycle auto-reload pulse.
    if (wr_ctrl || wr_preset || (state == LOAD)) flag_nxt = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            count_nxt = count - 32'd1;
          end else begin
            count_nxt = 32'd0;
            state_nxt = INT;
          end
        end
      end
      INT: begin
        flag_nxt = 1'b1;
        if (auto_rl) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
          if (!wr_ctrl) ctrl_nxt[0] = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      irq      <= flag_nxt & ctrl_nxt[3];
      if (wr_preset) preset <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr)
        2'd0:    rdata = {28'd0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: directed literal checks plus randomized bus traffic against a reference model.
module tb_timer_device;
`ifdef TIMER_PRESCALE_EN
  localparam int PSC = 4;
`else
  localparam int PSC = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  timer_device #(.PRESCALE(PSC)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 load, 2 counting, 3 expired.
  logic [3:0]  m_ctrl, n_ctrl, c_eff;
  logic [31:0] m_preset, m_count, n_pre, n_cnt;
  bit          m_flag, n_flag, w_ctrl, w_pre;
  int          m_phase, n_ph, m_psc, n_psc;

  always @(posedge clk) begin
    if (!reset) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
      m_flag = 1'b0; m_phase = 0; m_psc = 0;
    end else begin
      w_ctrl = sel && we && (addr == 2'd0);
      w_pre  = sel && we && (addr == 2'd1);
      c_eff  = w_ctrl ? wdata[3:0] : m_ctrl;
      n_ctrl = c_eff;
      n_pre  = w_pre ? wdata : m_preset;
      n_cnt  = m_count;
      n_flag = (w_ctrl || w_pre) ? 1'b0 : m_flag;
      n_ph   = m_phase;
      n_psc  = 0;
      if (m_phase == 0) begin
        if (c_eff[0]) n_ph = 1;
      end else if (m_phase == 1) begin
        n_cnt = m_preset; n_ph = 2; n_flag = 1'b0;
      end else if (m_phase == 2) begin
        if (!c_eff[0]) n_ph = 0;
        else if (m_psc + 1 < PSC) n_psc = m_psc + 1;
        else if (m_count <= 32'd1) begin n_cnt = 32'd0; n_ph = 3; end
        else n_cnt = m_count - 32'd1;
      end else begin
        n_flag = 1'b1;
        if (c_eff[2:1] == 2'b01) n_ph = 1;
        else begin n_ph = 0; if (!w_ctrl) n_ctrl[0] = 1'b0; end
      end
      m_ctrl = n_ctrl; m_preset = n_pre; m_count = n_cnt;
      m_flag = n_flag; m_phase = n_ph; m_psc = n_psc;
    end
  end

  logic [31:0] exp_r;
  logic        exp_irq;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_r = 32'd0;
      if (sel) begin
        if (addr == 2'd0)      exp_r = {28'd0, m_ctrl};
        else if (addr == 2'd1) exp_r = m_preset;
        else if (addr == 2'd2) exp_r = m_count;
      end
      exp_irq = m_flag & m_ctrl[3];
      vectors++;
      if (rdata !== exp_r || irq !== exp_irq) begin
        miscompares++;
        $display("FAIL cycle t=%0t sel=%b addr=%0d: rdata=%h irq=%b, required rdata=%h irq=%b",
                 $time, sel, addr, rdata, irq, exp_r, exp_irq);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
  endtask

  task automatic check_zeroed(input string tag);
    logic [31:0] v;
    rd(2'd0, v); check({tag, " ctrl"}, v, 32'd0);
    rd(2'd1, v); check({tag, " preset"}, v, 32'd0);
    rd(2'd2, v); check({tag, " count"}, v, 32'd0);
    check({tag, " irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] v, tmp;
    int r;
    reset = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    reset = 1'b1;
    check_zeroed("reset");

`ifdef TIMER_PRESCALE_EN
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      rd(2'd2, v);
      if (k == 4) check("psc count@4", v, 32'd2);
      if (k == 5) check("psc count@5", v, 32'd1);
      if (k == 9) check("psc count@9", v, 32'd0);
      if (k == 9) check("psc irq@9", {31'd0, irq}, 32'd0);
      if (k == 10) check("psc irq@10", {31'd0, irq}, 32'd1);
    end
`else
    // One-shot
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(2'd2, v);
      check($sformatf("oneshot count@%0d", k), v, 32'(6 - k));
      check($sformatf("oneshot irq low@%0d", k), {31'd0, irq}, 32'd0);
    end
    tick();
    check("oneshot irq@7", {31'd0, irq}, 32'd1);
    rd(2'd0, v);
    check("oneshot ctrl after", v, 32'h8);
    repeat (3) tick();
    check("oneshot irq held", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd5);
    check("oneshot irq cleared", {31'd0, irq}, 32'd0);

    // Auto-reload
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("auto irq@%0d", k), {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
    end

    // Mask and stop
    wr(2'd0, 32'h0);
    repeat (3) tick();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("mask irq@%0d", k), {31'd0, irq}, 32'd0);
    end
    rd(2'd2, v);
    check("mask count before stop", v, 32'd6);
    wr(2'd0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      rd(2'd2, v);
      check($sformatf("stop count hold %0d", k), v, 32'd6);
    end

    // Illegal and reserved accesses
    wr(2'd2, 32'h1234);
    rd(2'd2, v);
    check("count write ignored", v, 32'd6);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, v);
    check("ctrl reserved bits", v, 32'h0000_000F);
    rd(2'd3, v);
    check("addr3 reads zero", v, 32'd0);
    sel = 1'b0; addr = 2'd1; #1;
    check("sel low reads zero", rdata, 32'd0);
`endif

    // Reset mid-count after writes
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    check_zeroed("midcount reset");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      reset = (r == 0) ? 1'b0 : 1'b1;
      tmp = $urandom;
      addr = 2'($urandom);
      if (r < 12) begin
        sel = 1'b1; we = 1'b1;
        wdata = (addr == 2'd1) ? 32'($urandom_range(0, 12)) : tmp;
      end else if (r < 16) begin
        sel = 1'b0; we = 1'b1; wdata = tmp;
      end else if (r < 120) begin
        sel = 1'b1; we = 1'b0; wdata = tmp;
      end else begin
        sel = 1'b0; we = 1'b0; wdata = tmp;
      end
      tick();
    end
    sel = 1'b0; we = 1'b0; reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
